req_ack_window_gen: RTL
=======================

// Module: req_ack_window_gen
// PURPOSE
//  Request/acknowledge generator that drives the ack side of a bounded-latency
//  handshake: every req sample gets exactly one ack, MIN_LAT..MAX_LAT clock
//  edges later. It sits directly upstream of the concurrent check
//  "req |-> ##[MIN_LAT:MAX_LAT] ack" and produces the signal that check consumes.
//  Outstanding requests are buffered in an age-tracking FIFO.
//  A built-in monitor flags requests whose window expired because of stall.
// PARAMETERS
//  MIN_LAT  1   earliest edge (after the req edge) at which ack may be sampled
//  MAX_LAT  2   latest edge at which ack must be sampled; 1<=MIN_LAT<=MAX_LAT
//  DEPTH    4   max outstanding requests, >=1
//  AGE_W    3   age counter width; 2**AGE_W-1 > MAX_LAT (elaboration error otherwise)
// PORTS
//  clk       in   1               clock; all state updates on posedge
//  rst       in   1               synchronous, active-high reset
//  req       in   1               request; each posedge with req=1 is one request
//  stall     in   1               holds off ack while 1 (models busy responder)
//  ack       out  1               acknowledge; combinational from state and stall
//  pending   out  $clog2(DEPTH+1) outstanding request count
//  full      out  1               pending == DEPTH
//  drop      out  1               req lost this cycle (full, no pop)
//  late      out  1               sticky: some request missed its MAX_LAT window
//  late_cnt  out  8               count of late requests, saturates at 255
// BEHAVIOUR
//  - Reset (rst=1 at a posedge): FIFO emptied, late=0, late_cnt=0. While rst=1,
//    ack=0 and drop=0 are forced; req is ignored. Outputs after reset:
//    ack=0, pending=0, full=0, drop=0, late=0, late_cnt=0.
//  - Entry storage: valid and age[AGE_W-1:0] per slot; head is oldest.
//  - Push: at posedge with req=1 and (!full or pop at the same edge), the new
//    entry is written with age=1 (visible age after that edge).
//  - Aging: at every posedge, the age of each existing valid entry increments,
//    saturating at 2**AGE_W-1. A newly pushed entry is not aged at its push edge.
//  - ack = !rst && head_valid && head_age >= MIN_LAT && !stall.
//    Pop: head is removed at every posedge where ack=1. One pop per edge max.
//  - Latency: with stall=0 and empty FIFO, req at edge T -> ack sampled at T+MIN_LAT
//    (T+1 by default). Back-to-back reqs at T, T+1 -> acks at T+1, T+2.
//  - Push and pop at the same edge: both occur, pending is unchanged, legal when full.
//  - drop = !rst && req && full && !ack. The request is discarded and never acked.
//    No state change from a dropped request.
//  - Late detection: at each posedge, n = number of valid entries with
//    age == MAX_LAT that are not popped at that edge. If n>0, late<=1 and
//    late_cnt<=min(late_cnt+n,255). Each entry is counted exactly once
//    (age passes MAX_LAT only once).
//  - A late entry stays queued and is still acked when stall drops,
//    with strict order kept.
//  - late and late_cnt clear only on rst.
//  - Reset mid-operation: all pending requests are discarded with no ack.
//    Reset does not count them as late.
//  - pending and full are registered-state derived, with no comb path from req.
// TESTING
//  1 Reset: rst=1 for 2 edges with req=1 -> ack=0, drop=0, pending=0, late=0.
//  2 Single req at edge T, stall=0 -> ack=1 sampled at T+1 only, pending 1->0.
//  3 req high for 4 edges (T..T+3), stall=0 -> ack at T+1..T+4, pending
//    stays 1, late=0, and a checker for req |-> ##[1:2] ack passes.
//  4 Fill: stall=1, req for 5 edges, DEPTH=4 -> pending=4, full=1,
//    drop=1 on 5th edge, and late_cnt reaches 4 (each at age 2).
//  5 Release stall after case 4 -> acks on 4 consecutive edges, pending 4->0,
//    late stays 1, late_cnt=4.
//  6 Full + req + ack at the same edge (stall=0) -> push and pop both occur,
//    pending stays 4, drop=0. Then rst mid-queue -> pending=0 next cycle,
//    late_cnt=0, and no ack is seen.

Source files
------------

// File: rtl/req_ack_window_if.sv
// rtl/req_ack_window_if.sv - handshake and status bundle for the req/ack window generator
interface req_ack_window_if #(
    parameter int DEPTH = 4
) ();
    localparam int PW = $clog2(DEPTH + 1);

    logic          req;
    logic          stall;
    logic          ack;
    logic [PW-1:0] pending;
    logic          full;
    logic          drop;
    logic          late;
    logic [7:0]    late_cnt;

    modport master (
        output req,
        output stall,
        input  ack,
        input  pending,
        input  full,
        input  drop,
        input  late,
        input  late_cnt
    );

    modport slave (
        input  req,
        input  stall,
        output ack,
        output pending,
        output full,
        output drop,
        output late,
        output late_cnt
    );
endinterface

// File: rtl/req_ack_window_gen.sv
// rtl/req_ack_window_gen.sv - bounded-latency ack generator with age-tracking request FIFO
module req_ack_window_gen #(
    parameter int MIN_LAT = 1,
    parameter int MAX_LAT = 2,
    parameter int DEPTH   = 4,
    parameter int AGE_W   = 3
) (
    input  logic               clk,
    input  logic               rst,
    req_ack_window_if.slave    bus
);
    localparam int PW    = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SUM_W = ((PW > 8) ? PW : 8) + 1;

    localparam logic [AGE_W-1:0] AGE_MAX  = {AGE_W{1'b1}};
    localparam logic [AGE_W-1:0] AGE_MIN  = AGE_W'(MIN_LAT);
    localparam logic [AGE_W-1:0] AGE_LATE = AGE_W'(MAX_LAT);
    localparam logic [AGE_W-1:0] AGE_NEW  = AGE_W'(1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [PW-1:0]    CNT_FULL = PW'(DEPTH);
    localparam logic [SUM_W-1:0] CNT_SAT  = SUM_W'(255);

    generate
        if (MIN_LAT < 1 || MIN_LAT > MAX_LAT) begin : g_bad_lat
            $error("req_ack_window_gen: need 1 <= MIN_LAT <= MAX_LAT");
        end
        if (DEPTH < 1) begin : g_bad_depth
            $error("req_ack_window_gen: DEPTH must be at least 1");
        end
        if ((2 ** AGE_W) - 1 <= MAX_LAT) begin : g_bad_age
            $error("req_ack_window_gen: AGE_W too narrow for MAX_LAT");
        end
    endgenerate

    logic [DEPTH-1:0] slot_valid;
    logic [AGE_W-1:0] slot_age [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PW-1:0]    count;
    logic             late_q;
    logic [7:0]       late_cnt_q;

    logic             head_valid;
    logic [AGE_W-1:0] head_age;
    logic             full;
    logic             ack;
    logic             drop;
    logic             do_pop;
    logic             do_push;
    logic [PW-1:0]    late_n;
    logic [SUM_W-1:0] late_sum;
    logic [7:0]       late_cnt_next;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign head_valid = slot_valid[rd_ptr];
    assign head_age   = slot_age[rd_ptr];
    assign full       = (count == CNT_FULL);

    // ack depends only on registered state and stall, never on req
    assign ack     = !rst && head_valid && (head_age >= AGE_MIN) && !bus.stall;
    assign drop    = !rst && bus.req && full && !ack;
    assign do_pop  = ack;
    assign do_push = !rst && bus.req && (!full || do_pop);

    // Entries sitting at MAX_LAT that are not leaving now have missed their window
    always_comb begin
        late_n = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_valid[i] && (slot_age[i] == AGE_LATE) &&
                !(do_pop && (PTR_W'(i) == rd_ptr))) begin
                late_n = late_n + PW'(1);
            end
        end
    end

    assign late_sum      = SUM_W'(late_cnt_q) + SUM_W'(late_n);
    assign late_cnt_next = (late_sum > CNT_SAT) ? 8'hff : late_sum[7:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slot_age[i] <= '0;
            end
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            late_q     <= 1'b0;
            late_cnt_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (slot_valid[i] && (slot_age[i] != AGE_MAX)) begin
                    slot_age[i] <= slot_age[i] + AGE_W'(1);
                end
            end
            if (do_pop) begin
                slot_valid[rd_ptr] <= 1'b0;
                rd_ptr             <= ptr_inc(rd_ptr);
            end
            // When full, wr_ptr equals rd_ptr; the push below overrides the pop clear
            if (do_push) begin
                slot_valid[wr_ptr] <= 1'b1;
                slot_age[wr_ptr]   <= AGE_NEW;
                wr_ptr             <= ptr_inc(wr_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + PW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - PW'(1);
            end
            if (late_n != '0) begin
                late_q     <= 1'b1;
                late_cnt_q <= late_cnt_next;
            end
        end
    end

    assign bus.ack      = ack;
    assign bus.pending  = count;
    assign bus.full     = full;
    assign bus.drop     = drop;
    assign bus.late     = late_q;
    assign bus.late_cnt = late_cnt_q;
endmodule
